// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command controller.
//   state_t : controller state encoding
//   err_t   : completion result codes reported on err with done
//   PS2_*   : device response bytes
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      SHIFT     = 3'd3,
      RELEASE   = 3'd4,
      WAIT_RESP = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK           = 2'd0,
      ERR_TX_TIMEOUT   = 2'd1,
      ERR_RESP_TIMEOUT = 2'd2,
      ERR_RETRY        = 2'd3
   } err_t;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_BAT_OK = 8'hAA;

   // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_phase_timer.sv
// Phase timer for the PS/2 host controller: a loadable down-counter that
// stops at zero and flags terminal count.
//   clk, rst  : clock, synchronous active-high reset
//   load      : reload the counter with load_val (restarts the phase)
//   load_val  : number of cycles remaining minus one
//   expired   : counter has reached zero
module ps2_phase_timer #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign expired = (count == '0);

endmodule

// File: rtl/ps2_host_cmd.sv
// Host-to-device command controller for a PS/2 keyboard port.
// Inhibits the bus, issues request-to-send, shifts the command byte out on the
// device clock, checks the device ACK bit, then waits for the 0xFA / 0xFE
// response with bounded resend retries and per-phase timeouts.
//   clk, rst               : clock, synchronous active-high reset
//   cmd_data/valid/ready   : command handshake (accepted only in IDLE)
//   clock_in, data_in      : debounced PS/2 line levels
//   clock_oe, data_oe      : 1 = pull the corresponding line low
//   rx_inhibit             : receiver must ignore line activity
//   rx_valid, rx_byte      : byte completed by the shared receiver
//   busy, done, err        : status; err valid with done, held until next accept
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, cmd_ready high
// INHIBIT   | clock held low for INHIBIT_CYCLES
// REQ       | clock released, data pulled low (start bit)
// SHIFT     | data updated on each device clock fall, ACK sampled at fall 11
// RELEASE   | waiting for device to release both lines
// WAIT_RESP | receiver enabled, waiting for 0xFA / 0xFE
module ps2_host_cmd
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 1200,
   parameter int TIMEOUT_CYCLES = 240000,
   parameter int MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       clock_in,
   input  logic       data_in,
   output logic       clock_oe,
   output logic       data_oe,
   output logic       rx_inhibit,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       busy,
   output logic       done,
   output logic [1:0] err
);

   localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
   localparam int RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

   state_t        state, state_nxt;
   logic          clock_prev;
   logic          fall;
   logic [7:0]    cmd_q, cmd_nxt;
   logic          parity_q, parity_nxt;
   logic [RW-1:0] retry_q, retry_nxt;
   logic [3:0]    fall_cnt, fall_cnt_nxt;
   logic          accept;
   logic          done_evt;
   err_t          err_code;

   logic          clock_oe_nxt, data_oe_nxt, rx_inhibit_nxt;
   logic          busy_nxt, done_nxt, cmd_ready_nxt;
   logic [1:0]    err_nxt;

   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_expired;

   assign fall = clock_prev & ~clock_in;

   // Every state change restarts the phase; inside SHIFT each device clock
   // fall also restarts it, so the timeout bounds the gap between falls.
   assign tmr_load = (state_nxt != state) || ((state == SHIFT) && fall);
   assign tmr_val  = (state_nxt == INHIBIT) ? INH_LOAD : TMO_LOAD;

   ps2_phase_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         clock_prev <= 1'b1;
         cmd_q      <= '0;
         parity_q   <= 1'b0;
         retry_q    <= '0;
         fall_cnt   <= '0;
         clock_oe   <= 1'b0;
         data_oe    <= 1'b0;
         rx_inhibit <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 2'd0;
         cmd_ready  <= 1'b1;
      end else begin
         state      <= state_nxt;
         clock_prev <= clock_in;
         cmd_q      <= cmd_nxt;
         parity_q   <= parity_nxt;
         retry_q    <= retry_nxt;
         fall_cnt   <= fall_cnt_nxt;
         clock_oe   <= clock_oe_nxt;
         data_oe    <= data_oe_nxt;
         rx_inhibit <= rx_inhibit_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         cmd_ready  <= cmd_ready_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cmd_nxt      = cmd_q;
      parity_nxt   = parity_q;
      retry_nxt    = retry_q;
      fall_cnt_nxt = fall_cnt;
      accept       = 1'b0;
      done_evt     = 1'b0;
      err_code     = ERR_OK;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept     = 1'b1;
               cmd_nxt    = cmd_data;
               parity_nxt = odd_parity(cmd_data);
               retry_nxt  = '0;
               state_nxt  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (tmr_expired)
               state_nxt = REQ;
         end
         REQ: begin
            fall_cnt_nxt = '0;
            state_nxt    = SHIFT;
         end
         SHIFT: begin
            if (fall) begin
               fall_cnt_nxt = fall_cnt + 4'd1;
               // Fall 11: device drives the ACK bit low if it took the frame.
               if (fall_cnt == 4'd10) begin
                  if (!data_in) begin
                     state_nxt = RELEASE;
                  end else begin
                     state_nxt = IDLE;
                     done_evt  = 1'b1;
                     err_code  = ERR_TX_TIMEOUT;
                  end
               end
            end else if (tmr_expired) begin
               state_nxt = IDLE;
               done_evt  = 1'b1;
               err_code  = ERR_TX_TIMEOUT;
            end
         end
         RELEASE: begin
            if (clock_in && data_in) begin
               state_nxt = WAIT_RESP;
            end else if (tmr_expired) begin
               state_nxt = IDLE;
               done_evt  = 1'b1;
               err_code  = ERR_TX_TIMEOUT;
            end
         end
         WAIT_RESP: begin
            // Other bytes are scan codes already in flight; keep waiting.
            if (rx_valid) begin
               if (rx_byte == PS2_ACK) begin
                  state_nxt = IDLE;
                  done_evt  = 1'b1;
                  err_code  = ERR_OK;
               end else if (rx_byte == PS2_RESEND) begin
                  if (int'(retry_q) < MAX_RETRY) begin
                     retry_nxt = retry_q + RW'(1);
                     state_nxt = INHIBIT;
                  end else begin
                     state_nxt = IDLE;
                     done_evt  = 1'b1;
                     err_code  = ERR_RETRY;
                  end
               end
            end else if (tmr_expired) begin
               state_nxt = IDLE;
               done_evt  = 1'b1;
               err_code  = ERR_RESP_TIMEOUT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are computed from the next state so they change in the same
   // cycle the state register does.
   always_comb begin
      clock_oe_nxt   = (state_nxt == INHIBIT);
      rx_inhibit_nxt = (state_nxt inside {INHIBIT, REQ, SHIFT, RELEASE});
      busy_nxt       = (state_nxt != IDLE);
      cmd_ready_nxt  = (state_nxt == IDLE) && !done_evt;
      done_nxt       = done_evt;
      err_nxt        = err;
      if (accept)
         err_nxt = ERR_OK;
      if (done_evt)
         err_nxt = err_code;
      data_oe_nxt = 1'b0;
      if (state_nxt == REQ) begin
         data_oe_nxt = 1'b1;
      end else if (state_nxt == SHIFT) begin
         data_oe_nxt = data_oe;
         if ((state == SHIFT) && fall) begin
            if (fall_cnt < 4'd8)
               data_oe_nxt = ~cmd_q[fall_cnt[2:0]];
            else if (fall_cnt == 4'd8)
               data_oe_nxt = ~parity_q;
            else
               data_oe_nxt = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_cmd.sv
module tb_ps2_host_cmd;

   localparam int INH   = 1200;
   localparam int TMO   = 3000;
   localparam int RETRY = 3;
   localparam int HALF  = 20;
   localparam int BOUND = 20000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       clock_in, data_in;
   logic       clock_oe, data_oe;
   logic       rx_inhibit;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       busy, done;
   logic [1:0] err;

   logic dev_clk  = 1'b1;
   logic dev_data = 1'b1;

   // Open-drain wired-AND of host and device drivers.
   assign clock_in = dev_clk & ~clock_oe;
   assign data_in  = dev_data & ~data_oe;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   logic [10:0] exp_frame_q[$];
   logic [1:0]  exp_err_q[$];

   ps2_host_cmd #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .MAX_RETRY      (RETRY)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .clock_in   (clock_in),
      .data_in    (data_in),
      .clock_oe   (clock_oe),
      .data_oe    (data_oe),
      .rx_inhibit (rx_inhibit),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      #800000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // Frame as seen on the data line: start, 8 data bits LSB first, odd parity, stop.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic p;
      p = 1'b1;
      for (int i = 0; i < 8; i++) p = p ^ d[i];
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic do_reset();
      rst = 1'b1; cmd_valid = 1'b0; rx_valid = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic issue_cmd(input logic [7:0] d, output logic ok);
      int k;
      k = 0; ok = 1'b0;
      @(negedge clk);
      while (!cmd_ready && k < BOUND) begin @(negedge clk); k++; end
      if (!cmd_ready) return;
      cmd_data = d; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      ok = 1'b1;
   endtask

   // Device model: counts the inhibit window, then gives n_falls clock pulses,
   // recording the data line after each fall and driving ACK low at fall 11.
   task automatic device_frame(input int n_falls, output logic [10:0] fr, output int inh,
                               output logic inh_ok, output logic ok);
      int k;
      k = 0; ok = 1'b0; fr = '0; inh = 0; inh_ok = 1'b1;
      do begin @(negedge clk); k++; end while (!clock_oe && k < BOUND);
      if (!clock_oe) return;
      while (clock_oe && inh < BOUND) begin
         inh++; inh_ok &= rx_inhibit;
         @(negedge clk);
      end
      fr[0] = ~data_oe;
      inh_ok &= rx_inhibit;
      if (n_falls > 0) repeat (HALF) @(negedge clk);
      for (int i = 1; i <= n_falls; i++) begin
         if (i == 11) dev_data = 1'b0;
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (i <= 10) fr[i] = ~data_oe;
         inh_ok &= rx_inhibit;
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      dev_data = 1'b1;
      ok = 1'b1;
   endtask

   task automatic wait_release(output logic ok);
      int k;
      k = 0;
      while (rx_inhibit && k < BOUND) begin @(negedge clk); k++; end
      ok = !rx_inhibit;
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      rx_byte = b; rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic wait_done(output logic ok, output int cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < BOUND);
      ok = (done === 1'b1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({clock_oe, data_oe, rx_inhibit, busy, done} !== 5'b0) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 00000", {clock_oe, data_oe, rx_inhibit, busy, done});
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      n_checks++;
      if (err !== 2'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err); end
   endtask

   task automatic test_led_cmd();
      logic ok, inh_ok; logic [10:0] fr, ef; int inh, cyc; logic [1:0] ee;
      exp_frame_q.push_back(frame_of(8'hED));
      exp_err_q.push_back(2'd0);
      issue_cmd(8'hED, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL led_accept: got %b expected 1", ok); end
      device_frame(11, fr, inh, inh_ok, ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL led_frame_start: got %b expected 1", ok); end
      n_checks++;
      if (inh !== INH) begin n_fail++; $display("FAIL led_inhibit_len: got %0d expected %0d", inh, INH); end
      ef = exp_frame_q.pop_front();
      n_checks++;
      if (fr !== ef) begin n_fail++; $display("FAIL led_frame_bits: got %b expected %b", fr, ef); end
      n_checks++;
      if (fr[9] !== 1'b1) begin n_fail++; $display("FAIL led_parity: got %b expected 1", fr[9]); end
      n_checks++;
      if (inh_ok !== 1'b1) begin n_fail++; $display("FAIL led_rx_inhibit_held: got %b expected 1", inh_ok); end
      wait_release(ok);
      n_checks++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL led_release: got %b expected 1", ok); end
      send_rx(8'hFA);
      wait_done(ok, cyc);
      ee = exp_err_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || err !== ee) begin
         n_fail++; $display("FAIL led_done_err: done=%b err=%0d expected done=1 err=%0d", ok, err, ee);
      end
      n_checks++;
      if ({clock_oe, data_oe, rx_inhibit, busy, cmd_ready} !== 5'b0) begin
         n_fail++; $display("FAIL led_done_cycle: got %b expected 00000", {clock_oe, data_oe, rx_inhibit, busy, cmd_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({done, cmd_ready, err} !== 4'b0100) begin
         n_fail++; $display("FAIL led_after_done: got %b expected 0100", {done, cmd_ready, err});
      end
   endtask

   task automatic test_back_to_back_resend();
      logic ok, inh_ok; logic [10:0] fr, ef, first; int inh, cyc; logic [1:0] ee;
      for (int f = 0; f < 3; f++) exp_frame_q.push_back(frame_of(8'hFF));
      exp_err_q.push_back(2'd0);
      issue_cmd(8'hFF, ok);
      first = '0;
      for (int f = 0; f < 3; f++) begin
         device_frame(11, fr, inh, inh_ok, ok);
         ef = exp_frame_q.pop_front();
         if (f == 0) first = fr;
         n_checks++;
         if (ok !== 1'b1 || fr !== ef || inh !== INH) begin
            n_fail++; $display("FAIL resend_frame%0d: got ok=%b bits=%b inh=%0d expected ok=1 bits=%b inh=%0d", f, ok, fr, inh, ef, INH);
         end
         n_checks++;
         if (fr !== first) begin n_fail++; $display("FAIL resend_same_bits%0d: got %b expected %b", f, fr, first); end
         wait_release(ok);
         send_rx((f < 2) ? 8'hFE : 8'hFA);
      end
      wait_done(ok, cyc);
      ee = exp_err_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || err !== ee) begin
         n_fail++; $display("FAIL resend_done_err: done=%b err=%0d expected done=1 err=%0d", ok, err, ee);
      end
   endtask

   task automatic test_retry_exhausted();
      logic ok, inh_ok; logic [10:0] fr, ef; int inh, cyc; logic [1:0] ee;
      for (int f = 0; f < 4; f++) exp_frame_q.push_back(frame_of(8'hF3));
      exp_err_q.push_back(2'd3);
      issue_cmd(8'hF3, ok);
      for (int f = 0; f < 4; f++) begin
         device_frame(11, fr, inh, inh_ok, ok);
         ef = exp_frame_q.pop_front();
         n_checks++;
         if (ok !== 1'b1 || fr !== ef) begin
            n_fail++; $display("FAIL retry_frame%0d: got ok=%b bits=%b expected ok=1 bits=%b", f, ok, fr, ef);
         end
         wait_release(ok);
         send_rx(8'hFE);
      end
      wait_done(ok, cyc);
      ee = exp_err_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || err !== ee || cyc !== 1) begin
         n_fail++; $display("FAIL retry_done_err: done=%b err=%0d cyc=%0d expected done=1 err=%0d cyc=1", ok, err, cyc, ee);
      end
   endtask

   task automatic test_tx_timeout();
      logic ok, inh_ok; logic [10:0] fr; int inh, cyc; logic [1:0] ee;
      exp_err_q.push_back(2'd1);
      issue_cmd(8'hED, ok);
      device_frame(0, fr, inh, inh_ok, ok);
      n_checks++;
      if (ok !== 1'b1 || fr[0] !== 1'b0) begin
         n_fail++; $display("FAIL txto_req: got ok=%b start=%b expected ok=1 start=0", ok, fr[0]);
      end
      wait_done(ok, cyc);
      ee = exp_err_q.pop_front();
      // Counted from the REQ sample; SHIFT begins one cycle later.
      n_checks++;
      if (ok !== 1'b1 || err !== ee || cyc !== TMO + 1) begin
         n_fail++; $display("FAIL txto_done: done=%b err=%0d cyc=%0d expected done=1 err=%0d cyc=%0d", ok, err, cyc, ee, TMO + 1);
      end
      n_checks++;
      if ({clock_oe, data_oe} !== 2'b00) begin
         n_fail++; $display("FAIL txto_lines: got %b expected 00", {clock_oe, data_oe});
      end
   endtask

   task automatic test_scan_code_and_resp_timeout();
      logic ok, inh_ok; logic [10:0] fr, ef; int inh, cyc, base; logic [1:0] ee;
      exp_frame_q.push_back(frame_of(8'hF4));
      exp_err_q.push_back(2'd0);
      issue_cmd(8'hF4, ok);
      device_frame(11, fr, inh, inh_ok, ok);
      ef = exp_frame_q.pop_front();
      n_checks++;
      if (fr !== ef) begin n_fail++; $display("FAIL scan_frame: got %b expected %b", fr, ef); end
      wait_release(ok);
      base = done_cnt;
      send_rx(8'h1C);
      repeat (50) @(negedge clk);
      n_checks++;
      if (done_cnt !== base || busy !== 1'b1) begin
         n_fail++; $display("FAIL scan_ignored: dones=%0d busy=%b expected dones=%0d busy=1", done_cnt, busy, base);
      end
      send_rx(8'hFA);
      wait_done(ok, cyc);
      ee = exp_err_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || err !== ee) begin
         n_fail++; $display("FAIL scan_done_err: done=%b err=%0d expected done=1 err=%0d", ok, err, ee);
      end

      exp_frame_q.push_back(frame_of(8'hED));
      exp_err_q.push_back(2'd2);
      issue_cmd(8'hED, ok);
      device_frame(11, fr, inh, inh_ok, ok);
      ef = exp_frame_q.pop_front();
      n_checks++;
      if (fr !== ef) begin n_fail++; $display("FAIL respto_frame: got %b expected %b", fr, ef); end
      wait_release(ok);
      wait_done(ok, cyc);
      ee = exp_err_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || err !== ee || cyc !== TMO) begin
         n_fail++; $display("FAIL respto_done: done=%b err=%0d cyc=%0d expected done=1 err=%0d cyc=%0d", ok, err, cyc, ee, TMO);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic ok, inh_ok; logic [10:0] fr, ef; int inh, cyc, base; logic [1:0] ee;
      issue_cmd(8'hED, ok);
      device_frame(4, fr, inh, inh_ok, ok);
      base = done_cnt;
      dev_clk = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({clock_oe, data_oe, rx_inhibit, busy, done, cmd_ready} !== 6'b000001) begin
         n_fail++; $display("FAIL rst_mid_outputs: got %b expected 000001", {clock_oe, data_oe, rx_inhibit, busy, done, cmd_ready});
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (100) @(negedge clk);
      n_checks++;
      if (done_cnt !== base) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected %0d", done_cnt, base); end

      exp_frame_q.push_back(frame_of(8'hED));
      exp_err_q.push_back(2'd0);
      issue_cmd(8'hED, ok);
      device_frame(11, fr, inh, inh_ok, ok);
      ef = exp_frame_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || fr !== ef) begin
         n_fail++; $display("FAIL rst_new_frame: got ok=%b bits=%b expected ok=1 bits=%b", ok, fr, ef);
      end
      wait_release(ok);
      send_rx(8'hFA);
      wait_done(ok, cyc);
      ee = exp_err_q.pop_front();
      n_checks++;
      if (ok !== 1'b1 || err !== ee) begin
         n_fail++; $display("FAIL rst_new_done: done=%b err=%0d expected done=1 err=%0d", ok, err, ee);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rx_valid = 1'b0; rx_byte = '0;
      do_reset();
      test_reset();
      test_led_cmd();
      test_back_to_back_resend();
      test_retry_exhausted();
      test_tx_timeout();
      test_scan_code_and_resp_timeout();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
